// File: rtl/exec_cc_stage_pkg.sv
// Shared definitions for the execute-stage back half: encodings, RNONE, ifun conditions, E/M record.
// Optional macro EXEC_CC_CARRY_EN adds the unsigned (CF-based) condition codes.
package exec_cc_stage_pkg;

   localparam int DATA_W  = 64;
   localparam int REG_W   = 4;
   localparam int ICODE_W = 4;

   localparam logic [REG_W-1:0] RNONE = '1;

   typedef enum logic [1:0] {
      STAT_AOK = 2'd0,
      STAT_HLT = 2'd1,
      STAT_ADR = 2'd2,
      STAT_INS = 2'd3
   } stat_t;

   localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
   localparam logic [ICODE_W-1:0] I_CMOVXX = 4'h2;

   localparam logic [ICODE_W-1:0] C_YES = 4'd0;
   localparam logic [ICODE_W-1:0] C_LE  = 4'd1;
   localparam logic [ICODE_W-1:0] C_L   = 4'd2;
   localparam logic [ICODE_W-1:0] C_E   = 4'd3;
   localparam logic [ICODE_W-1:0] C_NE  = 4'd4;
   localparam logic [ICODE_W-1:0] C_GE  = 4'd5;
   localparam logic [ICODE_W-1:0] C_G   = 4'd6;
`ifdef EXEC_CC_CARRY_EN
   localparam logic [ICODE_W-1:0] C_B   = 4'd8;
   localparam logic [ICODE_W-1:0] C_A   = 4'd9;
`endif

   typedef struct packed {
      logic [ICODE_W-1:0] icode;
      logic               cnd;
      stat_t              stat;
      logic [DATA_W-1:0]  val_e;
      logic [DATA_W-1:0]  val_a;
      logic [REG_W-1:0]   dst_e;
      logic [REG_W-1:0]   dst_m;
   } em_reg_t;

   // A NOP bubble: what reset and M_bubble both load into the E/M register.
   localparam em_reg_t EM_NOP = '{
      icode: I_NOP,
      cnd:   1'b0,
      stat:  STAT_AOK,
      val_e: '0,
      val_a: '0,
      dst_e: RNONE,
      dst_m: RNONE
   };

endpackage

// File: rtl/exec_cc_stage_if.sv
// Bus between the ALU/hazard side of execute and the CC/E-M back half.
interface exec_cc_stage_if;
   import exec_cc_stage_pkg::*;

   logic [ICODE_W-1:0] e_icode;
   logic [ICODE_W-1:0] e_ifun;
   logic [1:0]         e_stat;
   logic [DATA_W-1:0]  e_valE;
   logic [DATA_W-1:0]  e_valA;
   logic [REG_W-1:0]   e_dstE;
   logic [REG_W-1:0]   e_dstM;
   logic               alu_zf;
   logic               alu_sf;
   logic               alu_of;
   logic               alu_cf;
   logic               set_cc;
   logic               m_exc;
   logic               M_stall;
   logic               M_bubble;

   logic               e_cnd;
   logic               cc_zf;
   logic               cc_sf;
   logic               cc_of;
   logic               cc_cf;
   logic [ICODE_W-1:0] M_icode;
   logic               M_cnd;
   logic [1:0]         M_stat;
   logic [DATA_W-1:0]  M_valE;
   logic [DATA_W-1:0]  M_valA;
   logic [REG_W-1:0]   M_dstE;
   logic [REG_W-1:0]   M_dstM;

   modport master (
      output e_icode, e_ifun, e_stat, e_valE, e_valA, e_dstE, e_dstM,
             alu_zf, alu_sf, alu_of, alu_cf, set_cc, m_exc, M_stall, M_bubble,
      input  e_cnd, cc_zf, cc_sf, cc_of, cc_cf,
             M_icode, M_cnd, M_stat, M_valE, M_valA, M_dstE, M_dstM
   );

   modport slave (
      input  e_icode, e_ifun, e_stat, e_valE, e_valA, e_dstE, e_dstM,
             alu_zf, alu_sf, alu_of, alu_cf, set_cc, m_exc, M_stall, M_bubble,
      output e_cnd, cc_zf, cc_sf, cc_of, cc_cf,
             M_icode, M_cnd, M_stat, M_valE, M_valA, M_dstE, M_dstM
   );

endinterface

// File: rtl/exec_cc_stage_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator; also reused by decode for prediction checks.
// With EXEC_CC_CARRY_EN, ifun 8/9 add unsigned below/above using CF.
module cond_eval
   import exec_cc_stage_pkg::*;
(
   input  logic [ICODE_W-1:0] ifun,
   input  logic               zf,
   input  logic               sf,
   input  logic               of,
`ifdef EXEC_CC_CARRY_EN
   input  logic               cf,
`endif
   output logic               cnd
);

   logic lt;
   assign lt = sf ^ of;

   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = lt | zf;
         C_L:     cnd = lt;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~zf;
`ifdef EXEC_CC_CARRY_EN
         C_B:     cnd = cf;
         C_A:     cnd = ~cf & ~zf;
`endif
         default: cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/exec_cc_stage.sv
// Execute back half: CC register, condition evaluation, cmov dstE gating and the E/M register.
// Define EXEC_CC_CARRY_EN to store CF and enable the unsigned conditions.
module exec_cc_stage
   import exec_cc_stage_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   exec_cc_stage_if.slave bus
);

   logic    zf_q, sf_q, of_q;
   logic    cf_q;
   logic    cnd;
   em_reg_t em_d, em_q;

   // CC only changes for flag-setting ops with no older exception; stalls do not block it.
   always_ff @(posedge clk) begin
      if (rst) begin
         zf_q <= 1'b1;
         sf_q <= 1'b0;
         of_q <= 1'b0;
      end else if (bus.set_cc && !bus.m_exc) begin
         zf_q <= bus.alu_zf;
         sf_q <= bus.alu_sf;
         of_q <= bus.alu_of;
      end
   end

`ifdef EXEC_CC_CARRY_EN
   always_ff @(posedge clk) begin
      if (rst)
         cf_q <= 1'b0;
      else if (bus.set_cc && !bus.m_exc)
         cf_q <= bus.alu_cf;
   end
`else
   logic unused_alu_cf;
   assign unused_alu_cf = bus.alu_cf;
   assign cf_q          = 1'b0;
`endif

   cond_eval u_cond_eval (
      .ifun (bus.e_ifun),
      .zf   (zf_q),
      .sf   (sf_q),
      .of   (of_q),
`ifdef EXEC_CC_CARRY_EN
      .cf   (cf_q),
`endif
      .cnd  (cnd)
   );

   // An untaken cmov must not write its destination, so its dstE becomes RNONE.
   always_comb begin
      em_d       = EM_NOP;
      em_d.icode = bus.e_icode;
      em_d.cnd   = cnd;
      em_d.stat  = stat_t'(bus.e_stat);
      em_d.val_e = bus.e_valE;
      em_d.val_a = bus.e_valA;
      em_d.dst_e = (bus.e_icode == I_CMOVXX && !cnd) ? RNONE : bus.e_dstE;
      em_d.dst_m = bus.e_dstM;
   end

   always_ff @(posedge clk) begin
      if (rst)
         em_q <= EM_NOP;
      else if (bus.M_stall)
         em_q <= em_q;
      else if (bus.M_bubble)
         em_q <= EM_NOP;
      else
         em_q <= em_d;
   end

   assign bus.e_cnd   = cnd;
   assign bus.cc_zf   = zf_q;
   assign bus.cc_sf   = sf_q;
   assign bus.cc_of   = of_q;
   assign bus.cc_cf   = cf_q;
   assign bus.M_icode = em_q.icode;
   assign bus.M_cnd   = em_q.cnd;
   assign bus.M_stat  = em_q.stat;
   assign bus.M_valE  = em_q.val_e;
   assign bus.M_valA  = em_q.val_a;
   assign bus.M_dstE  = em_q.dst_e;
   assign bus.M_dstM  = em_q.dst_m;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Scoreboard bench for exec_cc_stage: directed checks then randomized traffic against a reference model.
// Build with EXEC_CC_CARRY_EN defined to exercise the CF-based conditions.
module tb_exec_cc_stage;

   typedef struct {
      logic        rst;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [1:0]  stat;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
      logic        zf, sf, of, cf;
      logic        setCc, mExc, stall, bubble;
   } stim_t;

   typedef struct {
      logic [3:0]  icode;
      logic        cnd;
      logic [1:0]  stat;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
      logic        zf, sf, of, cf;
   } exp_t;

   logic clk;
   logic rst;
   exec_cc_stage_if bus();

   exec_cc_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   nVectors    = 0;
   int   nChecks     = 0;
   int   nMiscompares = 0;
   bit   modelValid  = 0;
   exp_t model;
   exp_t scoreboard[$];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Condition table evaluated straight from the flag meanings.
   function automatic logic modelCond(input logic [3:0] ifun, input exp_t m);
      logic less;
      less = (m.sf != m.of);
      case (ifun)
         4'd0: return 1'b1;
         4'd1: return less || m.zf;
         4'd2: return less;
         4'd3: return m.zf;
         4'd4: return !m.zf;
         4'd5: return !less;
         4'd6: return !less && !m.zf;
`ifdef EXEC_CC_CARRY_EN
         4'd8: return m.cf;
         4'd9: return !m.cf && !m.zf;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic stim_t idleStim();
      stim_t s;
      s.rst = 1'b0; s.icode = 4'h1; s.ifun = 4'h0; s.stat = 2'd0;
      s.valE = '0; s.valA = '0; s.dstE = 4'hF; s.dstM = 4'hF;
      s.zf = 1'b0; s.sf = 1'b0; s.of = 1'b0; s.cf = 1'b0;
      s.setCc = 1'b0; s.mExc = 1'b0; s.stall = 1'b0; s.bubble = 1'b0;
      return s;
   endfunction

   function automatic exp_t resetModel();
      exp_t m;
      m.icode = 4'h1; m.cnd = 1'b0; m.stat = 2'd0; m.valE = '0; m.valA = '0;
      m.dstE = 4'hF; m.dstM = 4'hF;
      m.zf = 1'b1; m.sf = 1'b0; m.of = 1'b0; m.cf = 1'b0;
      return m;
   endfunction

   // Drive one cycle of inputs, check e_cnd, predict the state after the edge.
   task automatic applyStimulus(input stim_t s);
      logic c;
      @(negedge clk);
      rst          = s.rst;
      bus.e_icode  = s.icode;
      bus.e_ifun   = s.ifun;
      bus.e_stat   = s.stat;
      bus.e_valE   = s.valE;
      bus.e_valA   = s.valA;
      bus.e_dstE   = s.dstE;
      bus.e_dstM   = s.dstM;
      bus.alu_zf   = s.zf;
      bus.alu_sf   = s.sf;
      bus.alu_of   = s.of;
      bus.alu_cf   = s.cf;
      bus.set_cc   = s.setCc;
      bus.m_exc    = s.mExc;
      bus.M_stall  = s.stall;
      bus.M_bubble = s.bubble;
      #1;
      c = modelCond(s.ifun, model);
      if (modelValid)
         checkOutput("e_cnd", {63'd0, bus.e_cnd}, {63'd0, c});
      nVectors++;
      if (s.rst) begin
         model      = resetModel();
         modelValid = 1;
      end else begin
         if (!s.stall) begin
            if (s.bubble) begin
               model.icode = 4'h1; model.cnd = 1'b0; model.stat = 2'd0;
               model.valE = '0; model.valA = '0; model.dstE = 4'hF; model.dstM = 4'hF;
            end else begin
               model.icode = s.icode;
               model.cnd   = c;
               model.stat  = s.stat;
               model.valE  = s.valE;
               model.valA  = s.valA;
               model.dstE  = (s.icode == 4'h2 && !c) ? 4'hF : s.dstE;
               model.dstM  = s.dstM;
            end
         end
         if (s.setCc && !s.mExc) begin
            model.zf = s.zf; model.sf = s.sf; model.of = s.of;
`ifdef EXEC_CC_CARRY_EN
            model.cf = s.cf;
`endif
         end
      end
      if (modelValid)
         scoreboard.push_back(model);
      @(posedge clk);
      #2;
   endtask

   task automatic peekCnd(input logic [3:0] ifun, input logic expected);
      bus.e_ifun = ifun;
      #1;
      checkOutput($sformatf("e_cnd_ifun%0d", ifun), {63'd0, bus.e_cnd}, {63'd0, expected});
   endtask

   // Monitor: every edge the E/M register and CC present a new value.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput("M_icode", {60'd0, bus.M_icode}, {60'd0, e.icode});
            checkOutput("M_cnd",   {63'd0, bus.M_cnd},   {63'd0, e.cnd});
            checkOutput("M_stat",  {62'd0, bus.M_stat},  {62'd0, e.stat});
            checkOutput("M_valE",  bus.M_valE, e.valE);
            checkOutput("M_valA",  bus.M_valA, e.valA);
            checkOutput("M_dstE",  {60'd0, bus.M_dstE},  {60'd0, e.dstE});
            checkOutput("M_dstM",  {60'd0, bus.M_dstM},  {60'd0, e.dstM});
            checkOutput("cc_zf",   {63'd0, bus.cc_zf},   {63'd0, e.zf});
            checkOutput("cc_sf",   {63'd0, bus.cc_sf},   {63'd0, e.sf});
            checkOutput("cc_of",   {63'd0, bus.cc_of},   {63'd0, e.of});
            checkOutput("cc_cf",   {63'd0, bus.cc_cf},   {63'd0, e.cf});
         end
      end
   end

   initial begin
      stim_t s;
      int    r;
      model = resetModel();

      s = idleStim();
      s.rst = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("rst_cc_zf",   {63'd0, bus.cc_zf},   64'd1);
      checkOutput("rst_cc_sf",   {63'd0, bus.cc_sf},   64'd0);
      checkOutput("rst_cc_of",   {63'd0, bus.cc_of},   64'd0);
      checkOutput("rst_M_icode", {60'd0, bus.M_icode}, 64'd1);
      checkOutput("rst_M_dstE",  {60'd0, bus.M_dstE},  64'hF);
      checkOutput("rst_M_stat",  {62'd0, bus.M_stat},  64'd0);

      s = idleStim();
      s.icode = 4'h6; s.setCc = 1'b1; s.sf = 1'b1;
      applyStimulus(s);
      checkOutput("opq_cc_sf", {63'd0, bus.cc_sf}, 64'd1);
      checkOutput("opq_cc_zf", {63'd0, bus.cc_zf}, 64'd0);
      peekCnd(4'd2, 1'b1);
      peekCnd(4'd6, 1'b0);

      s = idleStim();
      s.icode = 4'h6; s.setCc = 1'b1;
      applyStimulus(s);
      s = idleStim();
      s.icode = 4'h2; s.ifun = 4'd1; s.dstE = 4'h3;
      applyStimulus(s);
      checkOutput("cmovle_M_dstE", {60'd0, bus.M_dstE}, 64'hF);
      checkOutput("cmovle_M_cnd",  {63'd0, bus.M_cnd},  64'd0);

      s = idleStim();
      s.icode = 4'h6; s.setCc = 1'b1; s.zf = 1'b1;
      applyStimulus(s);
      s.zf = 1'b0; s.mExc = 1'b1;
      applyStimulus(s);
      checkOutput("exc_cc_zf", {63'd0, bus.cc_zf}, 64'd1);

      s = idleStim();
      s.icode = 4'h6; s.valE = 64'h1111;
      applyStimulus(s);
      checkOutput("load_M_valE", bus.M_valE, 64'h1111);
      s.valE = 64'h1234; s.icode = 4'h3; s.stall = 1'b1; s.bubble = 1'b1;
      applyStimulus(s);
      checkOutput("stall_M_valE",  bus.M_valE, 64'h1111);
      checkOutput("stall_M_icode", {60'd0, bus.M_icode}, 64'd6);
      s.stall = 1'b0;
      applyStimulus(s);
      checkOutput("bubble_M_icode", {60'd0, bus.M_icode}, 64'd1);
      checkOutput("bubble_M_valE",  bus.M_valE, 64'd0);

      s = idleStim();
      s.icode = 4'h6; s.setCc = 1'b1; s.cf = 1'b1;
      applyStimulus(s);
`ifdef EXEC_CC_CARRY_EN
      checkOutput("carry_cc_cf", {63'd0, bus.cc_cf}, 64'd1);
      peekCnd(4'd8, 1'b1);
`else
      checkOutput("carry_cc_cf", {63'd0, bus.cc_cf}, 64'd0);
      peekCnd(4'd8, 1'b0);
`endif

      for (int i = 0; i < 2000; i++) begin
         s = idleStim();
         r = $urandom_range(0, 3);
         s.icode  = (r == 0) ? 4'h1 : (r == 1) ? 4'h2 : (r == 2) ? 4'h7 : 4'($urandom_range(0, 15));
         s.ifun   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
         s.stat   = 2'($urandom_range(0, 3));
         s.valE   = {$urandom, $urandom};
         s.valA   = {$urandom, $urandom};
         s.dstE   = 4'($urandom_range(0, 15));
         s.dstM   = 4'($urandom_range(0, 15));
         s.zf     = 1'($urandom_range(0, 1));
         s.sf     = 1'($urandom_range(0, 1));
         s.of     = 1'($urandom_range(0, 1));
         s.cf     = 1'($urandom_range(0, 1));
         s.setCc  = 1'($urandom_range(0, 1));
         s.mExc   = ($urandom_range(0, 4) == 0);
         s.stall  = ($urandom_range(0, 5) == 0);
         s.bubble = ($urandom_range(0, 5) == 0);
         s.rst    = ($urandom_range(0, 59) == 0);
         applyStimulus(s);
      end

      if (scoreboard.size() != 0) begin
         nMiscompares++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
      end
      $display("[TB] %0d comparisons made", nChecks);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
